// File: rtl/bit_8_alu_mux.sv
// 8-bit ALU with PC-path 2:1 and address-path 4:1 selectors for the CPU datapath.
// Only the zero/negative/carry status flags are registered.
module bit_8_alu_mux (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [1:0] aluop,
  output logic [7:0] alu_out,
  input  logic       flag_en,
  output logic       zero,
  output logic       negative,
  output logic       carry,
  input  logic [7:0] m2_in0,
  input  logic [7:0] m2_in1,
  input  logic       m2_sel,
  output logic [7:0] m2_out,
  input  logic [7:0] m4_in0,
  input  logic [7:0] m4_in1,
  input  logic [7:0] m4_in2,
  input  logic [7:0] m4_in3,
  input  logic [1:0] m4_sel,
  output logic [7:0] m4_out
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Nine-bit sum so the carry-out (or no-borrow for subtraction) falls out of bit 8.
  function automatic logic [8:0] add_carry(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin);
    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
  endfunction

  logic [8:0] result;

  always_comb begin
    result = 9'd0;
    case (aluop)
      OP_ADD:  result = add_carry(alu_a, alu_b, 1'b0);
      OP_SUB:  result = add_carry(alu_a, ~alu_b, 1'b1);
      OP_AND:  result = {1'b0, alu_a & alu_b};
      OP_OR:   result = {1'b0, alu_a | alu_b};
      default: result = 9'd0;
    endcase
  end

  assign alu_out = result[7:0];

  always_comb begin
    m2_out = m2_sel ? m2_in1 : m2_in0;
  end

  always_comb begin
    m4_out = m4_in0;
    case (m4_sel)
      2'b00:   m4_out = m4_in0;
      2'b01:   m4_out = m4_in1;
      2'b10:   m4_out = m4_in2;
      2'b11:   m4_out = m4_in3;
      default: m4_out = m4_in0;
    endcase
  end

  // Flag register stage: captures the result present at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
    end else if (flag_en) begin
      zero     <= (result[7:0] == 8'd0);
      negative <= result[7];
      carry    <= result[8];
    end
  end

endmodule

// File: tb/tb_bit_8_alu_mux.sv
// Randomized and directed bench for bit_8_alu_mux against an integer-arithmetic reference.
module tb_bit_8_alu_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] alu_a = 8'd0, alu_b = 8'd0;
  logic [1:0] aluop = 2'd0;
  logic       flag_en = 1'b0;
  logic [7:0] alu_out;
  logic       zero, negative, carry;
  logic [7:0] m2_in0 = 8'd0, m2_in1 = 8'd0;
  logic       m2_sel = 1'b0;
  logic [7:0] m2_out;
  logic [7:0] m4_in0 = 8'd0, m4_in1 = 8'd0, m4_in2 = 8'd0, m4_in3 = 8'd0;
  logic [1:0] m4_sel = 2'd0;
  logic [7:0] m4_out;

  int errors = 0;
  int checks = 0;

  // Reference flag state and literal expectations posted by the stimulus.
  logic mz, mn, mc;
  logic flags_known = 1'b0;
  logic       lit_alu_en = 1'b0, lit_f_en = 1'b0, lit_m2_en = 1'b0, lit_m4_en = 1'b0;
  logic [7:0] lit_alu = 8'd0, lit_m2 = 8'd0, lit_m4 = 8'd0;
  logic       lit_z = 1'b0, lit_n = 1'b0, lit_c = 1'b0;

  always #5 clk = ~clk;

  bit_8_alu_mux dut (
    .clk(clk), .rst(rst),
    .alu_a(alu_a), .alu_b(alu_b), .aluop(aluop), .alu_out(alu_out),
    .flag_en(flag_en), .zero(zero), .negative(negative), .carry(carry),
    .m2_in0(m2_in0), .m2_in1(m2_in1), .m2_sel(m2_sel), .m2_out(m2_out),
    .m4_in0(m4_in0), .m4_in1(m4_in1), .m4_in2(m4_in2), .m4_in3(m4_in3),
    .m4_sel(m4_sel), .m4_out(m4_out)
  );

  // Returns {carry, result} from plain integer arithmetic.
  function automatic logic [8:0] ref_alu(input int a, input int b, input int op);
    int r;
    logic c;
    r = 0;
    c = 1'b0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b) > 255; end
      1: begin r = (a - b + 256) % 256; c = (a >= b); end
      2: r = a & b;
      default: r = a | b;
    endcase
    return {c, r[7:0]};
  endfunction

  always @(posedge clk) begin
    logic [8:0] r;
    r = ref_alu(int'(alu_a), int'(alu_b), int'(aluop));
    if (rst) begin
      mz <= 1'b0; mn <= 1'b0; mc <= 1'b0; flags_known <= 1'b1;
    end else if (flag_en) begin
      mz <= (r[7:0] == 8'd0); mn <= r[7]; mc <= r[8];
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] r;
    logic [7:0] m4_arr [4];
    r = ref_alu(int'(alu_a), int'(alu_b), int'(aluop));
    m4_arr[0] = m4_in0; m4_arr[1] = m4_in1; m4_arr[2] = m4_in2; m4_arr[3] = m4_in3;
    chk("alu_out", alu_out, r[7:0]);
    chk("m2_out", m2_out, m2_sel ? m2_in1 : m2_in0);
    chk("m4_out", m4_out, m4_arr[m4_sel]);
    if (flags_known) chk("flags", {5'd0, zero, negative, carry}, {5'd0, mz, mn, mc});
    if (lit_alu_en) chk("lit_alu", alu_out, lit_alu);
    if (lit_m2_en) chk("lit_m2", m2_out, lit_m2);
    if (lit_m4_en) chk("lit_m4", m4_out, lit_m4);
    if (lit_f_en) chk("lit_flags", {5'd0, zero, negative, carry}, {5'd0, lit_z, lit_n, lit_c});
  end

  task automatic cyc(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                     input logic fe, input logic r);
    @(posedge clk);
    #1;
    alu_a = a; alu_b = b; aluop = op; flag_en = fe; rst = r;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
    lit_alu_en = 1'b0; lit_f_en = 1'b0; lit_m2_en = 1'b0; lit_m4_en = 1'b0;
  endtask

  task automatic want_alu(input logic [7:0] v);
    lit_alu_en = 1'b1; lit_alu = v;
  endtask

  task automatic want_flags(input logic z, input logic n, input logic c);
    lit_f_en = 1'b1; lit_z = z; lit_n = n; lit_c = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    sample();
    cyc(8'hFF, 8'h01, 2'b00, 1'b1, 1'b0);
    want_alu(8'h00); sample();
    cyc(8'h05, 8'h07, 2'b01, 1'b1, 1'b0);
    want_alu(8'hFE); want_flags(1'b1, 1'b0, 1'b1); sample();
    cyc(8'h07, 8'h07, 2'b01, 1'b1, 1'b0);
    want_alu(8'h00); want_flags(1'b0, 1'b1, 1'b0); sample();
    cyc(8'hF0, 8'h3C, 2'b10, 1'b0, 1'b0);
    want_alu(8'h30); want_flags(1'b1, 1'b0, 1'b1); sample();
    cyc(8'hF0, 8'h3C, 2'b11, 1'b1, 1'b0);
    want_alu(8'hFC); want_flags(1'b1, 1'b0, 1'b1); sample();
    cyc(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    want_alu(8'h00); want_flags(1'b0, 1'b1, 1'b0); sample();
    cyc(8'h12, 8'h34, 2'b00, 1'b0, 1'b0);
    want_alu(8'h46); want_flags(1'b1, 1'b0, 1'b0); sample();
    cyc(8'h12, 8'h34, 2'b00, 1'b0, 1'b0);
    want_alu(8'h46); want_flags(1'b1, 1'b0, 1'b0); sample();
    // rst asserted between edges: flags unchanged until the next edge
    cyc(8'hFF, 8'h01, 2'b00, 1'b1, 1'b1);
    want_flags(1'b1, 1'b0, 1'b0); sample();
    cyc(8'h12, 8'h34, 2'b00, 1'b0, 1'b0);
    want_flags(1'b0, 1'b0, 1'b0); sample();

    cyc(8'h12, 8'h34, 2'b00, 1'b0, 1'b0);
    m2_in0 = 8'hA5; m2_in1 = 8'h3C; m2_sel = 1'b0;
    lit_m2_en = 1'b1; lit_m2 = 8'hA5; sample();
    cyc(8'h12, 8'h34, 2'b00, 1'b0, 1'b0);
    m2_sel = 1'b1;
    lit_m2_en = 1'b1; lit_m2 = 8'h3C; sample();

    m4_in0 = 8'h11; m4_in1 = 8'h22; m4_in2 = 8'h33; m4_in3 = 8'h44;
    for (int s = 0; s < 4; s++) begin
      cyc(8'h00, 8'h00, 2'b00, 1'b1, 1'b1);
      m4_sel = 2'(s);
      lit_m4_en = 1'b1; lit_m4 = 8'(8'h11 * (s + 1));
      sample();
    end

    for (int i = 0; i < 300; i++) begin
      cyc(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      m2_in0 = 8'($urandom); m2_in1 = 8'($urandom); m2_sel = 1'($urandom);
      m4_in0 = 8'($urandom); m4_in1 = 8'($urandom);
      m4_in2 = 8'($urandom); m4_in3 = 8'($urandom); m4_sel = 2'($urandom);
      sample();
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
